// File: rtl/softmax_stream_engine_if.sv
// rtl/softmax_stream_engine_if.sv - start/busy/done handshake and data bus of the softmax engine
interface softmax_stream_engine_if #(
  parameter int WIDTH     = 32,
  parameter int DIMENSION = 4
);
  logic                            start;
  logic                            mode;
  logic [DIMENSION-1:0][WIDTH-1:0] input_data;
  logic [DIMENSION-1:0][WIDTH-1:0] output_data;
  logic                            busy;
  logic                            done;

  modport master (output start, mode, input_data, input output_data, busy, done);
  modport slave  (input start, mode, input_data, output output_data, busy, done);
endinterface

// File: rtl/softmax_stream_engine.sv
// rtl/softmax_stream_engine.sv - sequential max-subtracted softmax / one-hot argmax engine
// Shift-based exp2 approximation, restoring divider, results published only in FIN.
module softmax_stream_engine #(
  parameter int WIDTH             = 32,
  parameter int DIMENSION         = 4,
  parameter int FIXED_POINT_INDEX = 16
) (
  input logic                    clk,
  input logic                    reset,
  softmax_stream_engine_if.slave bus
);
  localparam int F       = FIXED_POINT_INDEX;
  localparam int EW      = $clog2(DIMENSION);
  localparam int SW      = WIDTH + $clog2(DIMENSION);
  localparam int CNT_MAX = (DIMENSION > F + 1) ? DIMENSION : F + 1;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int PW      = WIDTH + F + 4;
  localparam int SHW     = $clog2(WIDTH);
  localparam real    LOG2E_R = 1.4426950408889634 * (2.0 ** F);
  localparam longint LOG2E   = longint'(LOG2E_R);
  localparam logic [WIDTH-1:0]     ONE  = WIDTH'(1) << F;
  localparam logic signed [PW-1:0] WLIM = PW'(WIDTH);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_MAX  = 3'd1;
  localparam logic [2:0] S_EXP  = 3'd2;
  localparam logic [2:0] S_DIV  = 3'd3;
  localparam logic [2:0] S_FIN  = 3'd4;

  logic [2:0]                      state_q, state_d;
  logic [CW-1:0]                   cnt_q, cnt_d;
  logic [EW-1:0]                   elem_q, elem_d;
  logic                            mode_q, mode_d;
  logic [DIMENSION-1:0][WIDTH-1:0] x_q, x_d, e_q, e_d, y_q, y_d, out_q, out_d;
  logic signed [WIDTH-1:0]         m_q, m_d;
  logic [EW-1:0]                   amax_q, amax_d;
  logic [SW-1:0]                   sum_q, sum_d;
  logic [SW-1:0]                   rem_q, rem_d;
  logic [F:0]                      numlo_q, numlo_d;
  logic [F-1:0]                    quo_q, quo_d;
  logic                            busy_q, busy_d, done_q, done_d;

  logic [EW-1:0]           sel;
  logic signed [WIDTH-1:0] xsel;
  logic signed [WIDTH:0]   diff;
  logic signed [PW-1:0]    prod, t, ip, neg_ip;
  logic [F-1:0]            frac;
  logic [WIDTH-1:0]        mant, e_val;
  logic [SW:0]             rem_shift;
  logic                    q_bit;
  logic [SW-1:0]           rem_next;

  assign sel    = cnt_q[EW-1:0];
  assign xsel   = signed'(x_q[sel]);
  // One extra bit so that x_i - m never wraps, even for full-range inputs.
  assign diff   = {xsel[WIDTH-1], xsel} - {m_q[WIDTH-1], m_q};
  assign prod   = PW'(diff) * PW'(LOG2E);
  assign t      = prod >>> F;
  assign ip     = t >>> F;
  assign frac   = t[F-1:0];
  assign neg_ip = -ip;
  assign mant   = ONE | {{(WIDTH-F){1'b0}}, frac};
  assign e_val  = (neg_ip >= WLIM) ? '0 : (mant >> neg_ip[SHW-1:0]);

  // Dividend is e << F; its top bits (e >> 1) are preloaded since they are already < sum.
  assign rem_shift = {rem_q, numlo_q[F]};
  assign q_bit     = rem_shift >= {1'b0, sum_q};
  assign rem_next  = q_bit ? SW'(rem_shift - {1'b0, sum_q}) : rem_shift[SW-1:0];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    elem_d  = elem_q;
    mode_d  = mode_q;
    x_d     = x_q;
    e_d     = e_q;
    y_d     = y_q;
    out_d   = out_q;
    m_d     = m_q;
    amax_d  = amax_q;
    sum_d   = sum_q;
    rem_d   = rem_q;
    numlo_d = numlo_q;
    quo_d   = quo_q;
    busy_d  = (state_q == S_MAX) || (state_q == S_EXP) || (state_q == S_DIV);
    done_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          x_d     = bus.input_data;
          mode_d  = bus.mode;
          cnt_d   = '0;
          state_d = S_MAX;
        end
      end
      S_MAX: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DIMENSION)) begin
          cnt_d   = '0;
          sum_d   = '0;
          state_d = mode_q ? S_FIN : S_EXP;
        end else if (cnt_q == '0 || xsel > m_q) begin
          m_d    = xsel;
          amax_d = sel;
        end
      end
      S_EXP: begin
        e_d[sel] = e_val;
        sum_d    = sum_q + SW'(e_val);
        cnt_d    = cnt_q + 1'b1;
        if (cnt_q == CW'(DIMENSION - 1)) begin
          cnt_d   = '0;
          elem_d  = '0;
          state_d = S_DIV;
        end
      end
      S_DIV: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '0) begin
          rem_d   = SW'(e_q[elem_q] >> 1);
          numlo_d = {e_q[elem_q][0], {F{1'b0}}};
          quo_d   = '0;
        end else begin
          rem_d   = rem_next;
          numlo_d = numlo_q << 1;
          quo_d   = F'({quo_q, q_bit});
          if (cnt_q == CW'(F + 1)) begin
            y_d[elem_q] = WIDTH'({quo_q, q_bit});
            cnt_d       = '0;
            elem_d      = elem_q + 1'b1;
            if (elem_q == EW'(DIMENSION - 1)) state_d = S_FIN;
          end
        end
      end
      S_FIN: begin
        for (int i = 0; i < DIMENSION; i++) begin
          out_d[i] = mode_q ? ((amax_q == EW'(i)) ? ONE : '0) : y_q[i];
        end
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      elem_q  <= '0;
      mode_q  <= 1'b0;
      x_q     <= '0;
      e_q     <= '0;
      y_q     <= '0;
      out_q   <= '0;
      m_q     <= '0;
      amax_q  <= '0;
      sum_q   <= '0;
      rem_q   <= '0;
      numlo_q <= '0;
      quo_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      elem_q  <= elem_d;
      mode_q  <= mode_d;
      x_q     <= x_d;
      e_q     <= e_d;
      y_q     <= y_d;
      out_q   <= out_d;
      m_q     <= m_d;
      amax_q  <= amax_d;
      sum_q   <= sum_d;
      rem_q   <= rem_d;
      numlo_q <= numlo_d;
      quo_q   <= quo_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign bus.output_data = out_q;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
endmodule

// File: tb/tb_softmax_stream_engine.sv
// tb/tb_softmax_stream_engine.sv - scoreboard bench for softmax_stream_engine
module tb_softmax_stream_engine;
  localparam int W = 32;
  localparam int D = 4;
  localparam int F = 16;

  typedef logic [D-1:0][W-1:0] vec_t;
  typedef struct {
    string name;
    vec_t  data;
    int    lat;
    int    sc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  logic prev_done = 1'b0;
  exp_t sb[$];

  softmax_stream_engine_if #(.WIDTH(W), .DIMENSION(D)) bus();

  softmax_stream_engine #(
    .WIDTH(W), .DIMENSION(D), .FIXED_POINT_INDEX(F)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic vec_t mk(logic [W-1:0] a0, logic [W-1:0] a1, logic [W-1:0] a2, logic [W-1:0] a3);
    vec_t v;
    v[0] = a0;
    v[1] = a1;
    v[2] = a2;
    v[3] = a3;
    return v;
  endfunction

  task automatic check(string name, logic [W-1:0] got, logic [W-1:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, want);
    end
  endtask

  // Monitor: pops the scoreboard whenever done is presented.
  always @(posedge clk) begin
    #1;
    if (reset) begin
      prev_done <= 1'b0;
    end else begin
      if (prev_done) check("done_single_pulse", {31'b0, bus.done}, 32'd0);
      if (bus.done) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_done: got done at cycle %0d, expected no done", cyc);
        end else begin
          automatic exp_t e;
          e = sb.pop_front();
          for (int i = 0; i < D; i++)
            check($sformatf("%s out[%0d]", e.name, i), bus.output_data[i], e.data[i]);
          check($sformatf("%s latency", e.name), cyc - e.sc, e.lat);
        end
      end
      prev_done <= bus.done;
    end
  end

  task automatic run(string name, logic md, vec_t din, vec_t want, bit pulses);
    automatic int   lat = md ? (D + 2) : (2 + 2 * D + D * (F + 2));
    automatic int   bc  = 0;
    automatic bit   got = 0;
    automatic exp_t e;
    bus.mode       = md;
    bus.input_data = din;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    e.name = name;
    e.data = want;
    e.lat  = lat;
    e.sc   = cyc;
    sb.push_back(e);
    bus.input_data = mk($urandom, $urandom, $urandom, $urandom);
    bus.mode       = ~md;
    for (int k = 1; k <= 400 && !got; k++) begin
      @(posedge clk);
      #1;
      bus.start = pulses && (k == 10 || k == 40);
      if (bus.done) got = 1;
      else if (bus.busy) bc++;
    end
    bus.start = 1'b0;
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: got no done in 400 cycles, expected done after %0d", name, lat);
      void'(sb.pop_back());
    end
    check($sformatf("%s busy_cycles", name), bc, lat - 1);
  endtask

  initial begin
    vec_t ramp, rev, ramp_out, rev_out;
    ramp     = mk(32'h10000, 32'h20000, 32'h30000, 32'h40000);
    rev      = mk(32'h40000, 32'h30000, 32'h20000, 32'h10000);
    ramp_out = mk(32'd2165, 32'd5775, 32'd16139, 32'd41454);
    rev_out  = mk(32'd41454, 32'd16139, 32'd5775, 32'd2165);
    bus.start      = 1'b0;
    bus.mode       = 1'b0;
    bus.input_data = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", {31'b0, bus.busy}, 32'd0);
    check("reset done", {31'b0, bus.done}, 32'd0);
    for (int i = 0; i < D; i++) check($sformatf("reset out[%0d]", i), bus.output_data[i], 32'd0);
    reset = 1'b0;
    @(posedge clk);
    #1;

    run("soft_ramp", 1'b0, ramp, ramp_out, 0);
    run("soft_reversed", 1'b0, rev, rev_out, 0);
    run("soft_zero", 1'b0, '0, mk(32'h4000, 32'h4000, 32'h4000, 32'h4000), 0);
    run("hard_tie", 1'b1, mk(32'h20000, 32'hFFFF0000, 32'h20000, 32'h8000),
        mk(32'h10000, 32'd0, 32'd0, 32'd0), 0);
    run("hard_negative", 1'b1, mk(32'hFFFD0000, 32'hFFFF0000, 32'hFFFE0000, 32'hFFFC0000),
        mk(32'd0, 32'h10000, 32'd0, 32'd0), 0);
    run("soft_extreme", 1'b0, mk(32'h7FFFFFFF, 32'h80000000, 32'd0, 32'd0),
        mk(32'd65536, 32'd0, 32'd0, 32'd0), 0);
    run("soft_start_pulses", 1'b0, ramp, ramp_out, 1);
    repeat (100) @(posedge clk);
    #1;

    bus.mode       = 1'b0;
    bus.input_data = rev;
    bus.start      = 1'b1;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    repeat (30) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("abort busy", {31'b0, bus.busy}, 32'd0);
    check("abort done", {31'b0, bus.done}, 32'd0);
    for (int i = 0; i < D; i++) check($sformatf("abort out[%0d]", i), bus.output_data[i], 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (100) @(posedge clk);
    #1;

    run("after_reset", 1'b0, rev, rev_out, 0);
    repeat (20) @(posedge clk);
    #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish by time limit, expected completion");
    $fatal(1, "watchdog");
  end
endmodule
